// File: rtl/cache_pkg.sv
// Shared encodings for the n-way cache metadata block: update opcodes and flush FSM states.
package cache_pkg;

  typedef enum logic [1:0] {
    OpTouch = 2'b00,
    OpFill  = 2'b01,
    OpInval = 2'b10,
    OpDirty = 2'b11
  } up_op_e;

  typedef enum logic {
    StIdle,
    StFlush
  } flush_state_e;

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU helper: victim selection from the node bits and the node bits
// that result from an access. Node k has children 2k+1 / 2k+2; a bit of 1 points right.
module plru_tree #(
  parameter int unsigned WAYS = 4,
  localparam int unsigned WB = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] bits,
  input  logic [WB-1:0]   access_way,
  output logic [WB-1:0]   victim,
  output logic [WAYS-2:0] next_bits
);

  always_comb begin
    int unsigned node;
    victim = '0;
    node   = 0;
    for (int unsigned lvl = 0; lvl < WB; lvl++) begin
      victim[WB-1-lvl] = bits[node];
      node = bits[node] ? 2 * node + 2 : 2 * node + 1;
    end
  end

  // Each node on the accessed path is set to point at the other subtree.
  always_comb begin
    int unsigned node;
    next_bits = bits;
    node      = 0;
    for (int unsigned lvl = 0; lvl < WB; lvl++) begin
      next_bits[node] = ~access_way[WB-1-lvl];
      node = access_way[WB-1-lvl] ? 2 * node + 2 : 2 * node + 1;
    end
  end

endmodule

// File: rtl/cache_meta_nway.sv
// N-way set-associative cache metadata (valid/tag/tree-PLRU) with lookup, update and flush.
// Optional per-way dirty bits and rs_victim_dirty port are enabled by CACHE_META_DIRTY_EN.
module cache_meta_nway
  import cache_pkg::*;
#(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned INDEX_BIT = 4,
  parameter int unsigned TAG_WIDTH = 20,
  localparam int unsigned WB = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lk_valid,
  output logic                 lk_ready,
  input  logic [INDEX_BIT-1:0] lk_index,
  input  logic [TAG_WIDTH-1:0] lk_tag,
  output logic                 rs_valid,
  output logic                 rs_hit,
  output logic [WB-1:0]        rs_way,
  output logic                 rs_victim_valid,
  output logic [TAG_WIDTH-1:0] rs_victim_tag,
`ifdef CACHE_META_DIRTY_EN
  output logic                 rs_victim_dirty,
`endif
  input  logic                 up_valid,
  input  logic [1:0]           up_op,
  input  logic [INDEX_BIT-1:0] up_index,
  input  logic [WB-1:0]        up_way,
  input  logic [TAG_WIDTH-1:0] up_tag,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done
);

  localparam int unsigned SETS = 1 << INDEX_BIT;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-2:0] plru_q;
  logic [TAG_WIDTH-1:0]      tag_q [SETS][WAYS];
`ifdef CACHE_META_DIRTY_EN
  logic [SETS-1:0][WAYS-1:0] dirty_q;
  logic                      rs_vd_q;
`endif

  flush_state_e         state_q, state_d;
  logic [INDEX_BIT-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;

  logic                 rs_valid_q, rs_hit_q, rs_vv_q;
  logic [WB-1:0]        rs_way_q;
  logic [TAG_WIDTH-1:0] rs_vt_q;

  logic                 accept, upd_en;
  logic [WAYS-1:0]      set_valid;
  logic                 hit, inv_found;
  logic [WB-1:0]        hit_way, inv_way, plru_victim, victim_way;
  logic [WAYS-2:0]      plru_touched;
  logic [WB-1:0]        unused_victim;
  logic [WAYS-2:0]      unused_next;

  assign flush_busy = (state_q == StFlush);
  assign lk_ready   = ~flush_busy;
  assign flush_done = done_q;
  assign accept     = lk_valid & lk_ready;
  assign upd_en     = up_valid & ~flush_busy;
  assign set_valid  = valid_q[lk_index];

  plru_tree #(.WAYS(WAYS)) u_plru_lookup (
    .bits       (plru_q[lk_index]),
    .access_way ('0),
    .victim     (plru_victim),
    .next_bits  (unused_next)
  );

  plru_tree #(.WAYS(WAYS)) u_plru_update (
    .bits       (plru_q[up_index]),
    .access_way (up_way),
    .victim     (unused_victim),
    .next_bits  (plru_touched)
  );

  // Descending scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_valid[w] && (tag_q[lk_index][w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!set_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
    victim_way = inv_found ? inv_way : plru_victim;
  end

  // Results are taken from pre-edge state, which gives read-before-write for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_valid_q <= 1'b0;
      rs_hit_q   <= 1'b0;
      rs_way_q   <= '0;
      rs_vv_q    <= 1'b0;
      rs_vt_q    <= '0;
`ifdef CACHE_META_DIRTY_EN
      rs_vd_q    <= 1'b0;
`endif
    end else begin
      rs_valid_q <= accept;
      if (accept) begin
        rs_hit_q <= hit;
        rs_way_q <= hit ? hit_way : victim_way;
        rs_vv_q  <= set_valid[victim_way];
        rs_vt_q  <= set_valid[victim_way] ? tag_q[lk_index][victim_way] : '0;
`ifdef CACHE_META_DIRTY_EN
        rs_vd_q  <= dirty_q[lk_index][victim_way];
`endif
      end
    end
  end

  assign rs_valid        = rs_valid_q;
  assign rs_hit          = rs_hit_q;
  assign rs_way          = rs_way_q;
  assign rs_victim_valid = rs_vv_q;
  assign rs_victim_tag   = rs_vt_q;
`ifdef CACHE_META_DIRTY_EN
  assign rs_victim_dirty = rs_vd_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d = StFlush;
          cnt_d   = '0;
        end
      end
      StFlush: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      plru_q  <= '0;
`ifdef CACHE_META_DIRTY_EN
      dirty_q <= '0;
`endif
    end else if (flush_busy) begin
      valid_q[cnt_q] <= '0;
      plru_q[cnt_q]  <= '0;
`ifdef CACHE_META_DIRTY_EN
      dirty_q[cnt_q] <= '0;
`endif
    end else if (up_valid) begin
      unique case (up_op_e'(up_op))
        OpTouch: plru_q[up_index] <= plru_touched;
        OpFill: begin
          valid_q[up_index][up_way] <= 1'b1;
          plru_q[up_index]          <= plru_touched;
`ifdef CACHE_META_DIRTY_EN
          dirty_q[up_index][up_way] <= 1'b0;
`endif
        end
        OpInval: begin
          valid_q[up_index][up_way] <= 1'b0;
`ifdef CACHE_META_DIRTY_EN
          dirty_q[up_index][up_way] <= 1'b0;
`endif
        end
        OpDirty: begin
`ifdef CACHE_META_DIRTY_EN
          dirty_q[up_index][up_way] <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Tag storage carries no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (upd_en && (up_op == OpFill)) begin
      tag_q[up_index][up_way] <= up_tag;
    end
  end

endmodule
